// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
// Shares one sign/zero immediate extender between two requesters
// (0 = ALU-immediate path, 1 = branch-offset path) through a single
// registered output slot. Round-robin arbitration, one-cycle latency,
// one result per cycle when the consumer keeps out_ready high.
//
// Optional feature: define IMM_EXT_LUI_EN to enable mode 2'b10
// ("upper": imm placed in the top I bits). Without it, mode 2'b10 is
// reserved, behaves like zero-extend and sets the sticky error flag.
module imm_ext_arbiter #(
    parameter int N = 32,
    parameter int I = N / 2
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    input  logic [I-1:0] req0_imm,
    input  logic [1:0]   req0_mode,
    output logic         req0_ready,

    input  logic         req1_valid,
    input  logic [I-1:0] req1_imm,
    input  logic [1:0]   req1_mode,
    output logic         req1_ready,

    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready,

    output logic         err
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         id_q, id_d;
    logic         last_id_q, last_id_d;
    logic         err_q, err_d;

    logic         slot_free;
    logic         gnt_any;
    logic         gnt_id;
    logic [I-1:0] sel_imm;
    logic [1:0]   sel_mode;

    // Extend an immediate according to its mode; reserved modes zero-extend.
    function automatic logic [N-1:0] extend(input logic [I-1:0] imm,
                                            input logic [1:0]   mode);
        case (mode)
            2'b00:   return {{(N-I){imm[I-1]}}, imm};
`ifdef IMM_EXT_LUI_EN
            2'b10:   return {imm, {(N-I){1'b0}}};
`endif
            default: return {{(N-I){1'b0}}, imm};
        endcase
    endfunction

    // Modes that are not architecturally defined in this build.
    function automatic logic is_reserved(input logic [1:0] mode);
`ifdef IMM_EXT_LUI_EN
        return (mode == 2'b11);
`else
        return mode[1];
`endif
    endfunction

    // Round-robin grant, only when the output slot is free this cycle.
    always_comb begin
        slot_free = (state_q == ST_EMPTY) || out_ready;
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        if (slot_free) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = ~last_id_q;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
        // Readies are forced low while reset is asserted, even though the
        // slot looks free then.
        req0_ready = rst_n & gnt_any & ~gnt_id;
        req1_ready = rst_n & gnt_any & gnt_id;
        sel_imm    = gnt_id ? req1_imm  : req0_imm;
        sel_mode   = gnt_id ? req1_mode : req0_mode;
    end

    // Next-state for the output slot, arbitration pointer and error flag.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        err_d     = err_q;
        if (gnt_any) begin
            state_d   = ST_FULL;
            data_d    = extend(sel_imm, sel_mode);
            id_d      = gnt_id;
            last_id_d = gnt_id;
            err_d     = err_q | is_reserved(sel_mode);
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d   = ST_EMPTY;
        end
    end

    // State registers; last_id resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed testbench for imm_ext_arbiter (N=32, I=16).
module tb_imm_ext_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_imm, req1_imm;
    logic [1:0]  req0_mode, req1_mode;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    imm_ext_arbiter #(.N(32), .I(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_imm   = 16'h8000;
        req0_mode  = 2'b00;
        req1_valid = 1'b0;
        req1_imm   = 16'h0000;
        req1_mode  = 2'b00;

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_err", err, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);

        // Release reset between edges; first grant on the next edge
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("first_req0_ready", req0_ready, 1);
        chk("first_req1_ready", req1_ready, 0);
        tick();
        chk("sext_valid", out_valid, 1);
        chk("sext_data", out_data, 32'hFFFF8000);
        chk("sext_id", out_id, 0);

        // No request, out_ready high: slot drains
        req0_valid = 1'b0;
        #1;
        chk("idle_req0_ready", req0_ready, 0);
        tick();
        chk("drain_valid", out_valid, 0);

        // Zero extend, then reserved mode 11
        req0_valid = 1'b1;
        req0_imm   = 16'h8000;
        req0_mode  = 2'b01;
        tick();
        chk("zext_data", out_data, 32'h00008000);
        chk("zext_err", err, 0);
        req0_mode = 2'b11;
        tick();
        chk("rsv_valid", out_valid, 1);
        chk("rsv_data", out_data, 32'h00008000);
        chk("rsv_err", err, 1);

        // Asynchronous reset while the slot is full
        req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_id", out_id, 0);
        chk("arst_err", err, 0);
        req0_valid = 1'b1;
        req0_imm   = 16'h7FFF;
        req0_mode  = 2'b00;
        req1_valid = 1'b1;
        req1_imm   = 16'h8001;
        req1_mode  = 2'b01;
        #1;
        rst_n = 1'b1;
        #1;
        chk("tie_req0_ready", req0_ready, 1);
        chk("tie_req1_ready", req1_ready, 0);

        // Both requesting every cycle: ids alternate starting with 0
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_id", out_id, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_data", out_data, (i % 2 == 0) ? 32'h00007FFF : 32'h00008001);
        end

        // Stall: slot holds req1's result, req1 pending with new data
        out_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_imm   = 16'hABCD;
        req1_mode  = 2'b00;
        #1;
        chk("stall_req1_ready", req1_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 32'h00008001);
            chk("stall_id", out_id, 1);
            chk("stall_ready", req1_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_req1_ready", req1_ready, 1);
        tick();
        chk("unstall_data", out_data, 32'hFFFFABCD);
        chk("unstall_id", out_id, 1);

        // Mode 10: upper when enabled, reserved otherwise
        req1_imm  = 16'h1234;
        req1_mode = 2'b10;
        tick();
`ifdef IMM_EXT_LUI_EN
        chk("lui_data", out_data, 32'h12340000);
        chk("lui_err", err, 0);
`else
        chk("lui_data", out_data, 32'h00001234);
        chk("lui_err", err, 1);
`endif

        // Requests withdrawn: slot empties
        req1_valid = 1'b0;
        #1;
        chk("end_req1_ready", req1_ready, 0);
        tick();
        chk("end_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
